// File: rtl/tx_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tx_arb_pkg
// Brief   : Shared encodings and helpers for the host transmitter arbiter.
// Revision: 1.0
// ============================================================================
package tx_arb_pkg;

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_ISSUE     = 2'd1;
    localparam logic [1:0] c_ST_WAIT_ACK  = 2'd2;
    localparam logic [1:0] c_ST_WAIT_DONE = 2'd3;

    localparam logic c_SRC_RD   = 1'b0;
    localparam logic c_SRC_META = 1'b1;

    // Bits needed to hold values 0..value-1 (never less than one bit).
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) width++;
        return (width < 1) ? 1 : width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tx_arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module  : tx_arb_watchdog
// Brief   : Idle counter for a locked metadata message; pulses o_expire on
//           the META_TIMEOUT-th consecutive idle cycle.
// Revision: 1.0
// ============================================================================
module tx_arb_watchdog
    import tx_arb_pkg::*;
#(
    parameter int META_TIMEOUT = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic i_lock,
    input  logic i_idle,
    input  logic i_transfer,
    output logic o_expire
);

    localparam int                 c_CNT_W = clog2(META_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(META_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_count;

    // Fires during the last idle cycle so the release lands on the next edge.
    assign o_expire = i_lock && i_idle && (r_count == c_LIMIT);

    always_ff @(posedge clock) begin
        if (reset || !i_lock || i_transfer) begin
            r_count <= '0;
        end else if (o_expire) begin
            r_count <= '0;
        end else if (i_idle) begin
            r_count <= r_count + c_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tx_arbiter
// Brief   : Round-robin sharing of the host transmitter between readback
//           words and atomic multi-word metadata messages.
//           Optional statistics counters: define TX_ARBITER_STATS_EN.
// Revision: 1.0
// ============================================================================
module tx_arbiter
    import tx_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int META_TIMEOUT = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rd_send,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_busy,
    input  logic                  meta_valid,
    input  logic [DATA_WIDTH-1:0] meta_data,
    input  logic                  meta_last,
    output logic                  meta_ready,
    output logic                  meta_abort,
    output logic                  tx_send,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_busy
`ifdef TX_ARBITER_STATS_EN
    ,
    output logic [31:0]           stat_rd_words,
    output logic [31:0]           stat_meta_words,
    output logic [15:0]           stat_aborts
`endif
);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_rr_ptr;
    logic                  r_meta_lock;
    logic                  r_rd_busy;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_src;
    logic                  r_last;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_meta_abort;
    logic                  w_sel_rd;
    logic                  w_sel_meta;
    logic                  w_expire;
    logic                  w_idle_wait;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_rd    = 1'b0;
        w_sel_meta  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                // A locked message owns the transmitter until its last word.
                if (r_meta_lock) begin
                    w_sel_meta = meta_valid;
                end else if (r_rd_busy && meta_valid) begin
                    w_sel_rd   = (r_rr_ptr == c_SRC_RD);
                    w_sel_meta = (r_rr_ptr == c_SRC_META);
                end else begin
                    w_sel_rd   = r_rd_busy;
                    w_sel_meta = meta_valid;
                end
                if (w_sel_rd || w_sel_meta) w_state_nxt = c_ST_ISSUE;
            end
            c_ST_ISSUE:     w_state_nxt = c_ST_WAIT_ACK;
            c_ST_WAIT_ACK:  w_state_nxt = c_ST_WAIT_DONE;
            c_ST_WAIT_DONE: if (!tx_busy) w_state_nxt = c_ST_IDLE;
            default:        w_state_nxt = c_ST_IDLE;
        endcase
    end

    assign w_idle_wait = (r_state == c_ST_IDLE) && !meta_valid;

    tx_arb_watchdog #(
        .META_TIMEOUT (META_TIMEOUT)
    ) u_watchdog (
        .clock      (clock),
        .reset      (reset),
        .i_lock     (r_meta_lock),
        .i_idle     (w_idle_wait),
        .i_transfer (w_sel_meta),
        .o_expire   (w_expire)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr     <= c_SRC_RD;
            r_meta_lock  <= 1'b0;
            r_rd_busy    <= 1'b0;
            r_hold       <= '0;
            r_src        <= c_SRC_RD;
            r_last       <= 1'b0;
            r_tx_data    <= '0;
            r_meta_abort <= 1'b0;
        end else begin
            r_meta_abort <= w_expire;
            if (rd_send && !r_rd_busy) begin
                r_hold    <= rd_data;
                r_rd_busy <= 1'b1;
            end
            if (w_sel_rd) begin
                r_tx_data <= r_hold;
                r_src     <= c_SRC_RD;
                r_last    <= 1'b1;
            end else if (w_sel_meta) begin
                r_tx_data <= meta_data;
                r_src     <= c_SRC_META;
                r_last    <= meta_last;
            end
            // The pointer only moves at message boundaries.
            if (r_state == c_ST_ISSUE) begin
                if (r_src == c_SRC_RD) begin
                    r_rd_busy <= 1'b0;
                    r_rr_ptr  <= c_SRC_META;
                end else if (r_last) begin
                    r_meta_lock <= 1'b0;
                    r_rr_ptr    <= c_SRC_RD;
                end else begin
                    r_meta_lock <= 1'b1;
                end
            end
            if (w_expire) begin
                r_meta_lock <= 1'b0;
                r_rr_ptr    <= c_SRC_RD;
            end
        end
    end

    assign rd_busy    = r_rd_busy;
    assign meta_ready = w_sel_meta;
    assign meta_abort = r_meta_abort;
    assign tx_send    = (r_state == c_ST_ISSUE);
    assign tx_data    = r_tx_data;

`ifdef TX_ARBITER_STATS_EN
    logic [31:0] r_stat_rd;
    logic [31:0] r_stat_meta;
    logic [15:0] r_stat_abort;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stat_rd    <= '0;
            r_stat_meta  <= '0;
            r_stat_abort <= '0;
        end else begin
            if (r_state == c_ST_ISSUE) begin
                if (r_src == c_SRC_RD) r_stat_rd   <= r_stat_rd + 32'd1;
                else                   r_stat_meta <= r_stat_meta + 32'd1;
            end
            if (w_expire) r_stat_abort <= r_stat_abort + 16'd1;
        end
    end

    assign stat_rd_words   = r_stat_rd;
    assign stat_meta_words = r_stat_meta;
    assign stat_aborts     = r_stat_abort;
`endif

endmodule
`default_nettype wire
